// File: rtl/mem_wait_bridge.sv
// Req/ack bridge between a single-cycle memory strobe interface and a wait-state memory.
// Holds the controller with stall and aborts unanswered accesses after TIMEOUT wait cycles.
module mem_wait_bridge #(
  parameter int WIDTH   = 8,
  parameter int AWIDTH  = 8,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [AWIDTH-1:0] cpu_adr,
  input  logic [WIDTH-1:0]  cpu_wd,
  input  logic              cpu_memread,
  input  logic              cpu_memwrite,
  output logic [WIDTH-1:0]  cpu_rd,
  output logic              stall,
  output logic [AWIDTH-1:0] mem_adr,
  output logic [WIDTH-1:0]  mem_wd,
  output logic              mem_we,
  output logic              mem_req,
  input  logic              mem_ack,
  input  logic [WIDTH-1:0]  mem_rd,
  output logic              err
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]  cpu_rd_q, cpu_rd_d;
  logic [AWIDTH-1:0] mem_adr_q, mem_adr_d;
  logic [WIDTH-1:0]  mem_wd_q, mem_wd_d;
  logic              mem_we_q, mem_we_d;
  logic              mem_req_q, mem_req_d;
  logic              err_q, err_d;
  logic              cpu_req;

  assign cpu_req = cpu_memread | cpu_memwrite;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      cpu_rd_q  <= '0;
      mem_adr_q <= '0;
      mem_wd_q  <= '0;
      mem_we_q  <= 1'b0;
      mem_req_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cpu_rd_q  <= cpu_rd_d;
      mem_adr_q <= mem_adr_d;
      mem_wd_q  <= mem_wd_d;
      mem_we_q  <= mem_we_d;
      mem_req_q <= mem_req_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cpu_rd_d  = cpu_rd_q;
    mem_adr_d = mem_adr_q;
    mem_wd_d  = mem_wd_q;
    mem_we_d  = mem_we_q;
    mem_req_d = mem_req_q;
    err_d     = err_q;

    unique case (state_q)
      S_IDLE: begin
        if (cpu_req) begin
          // A simultaneous read and write is treated as a write.
          mem_adr_d = cpu_adr;
          mem_wd_d  = cpu_wd;
          mem_we_d  = cpu_memwrite;
          mem_req_d = 1'b1;
          cnt_d     = '0;
          state_d   = S_WAIT;
        end
      end
      S_WAIT: begin
        if (mem_ack) begin
          if (!mem_we_q) cpu_rd_d = mem_rd;
          mem_req_d = 1'b0;
          state_d   = S_DONE;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          // Aborted reads return all ones so the fault is visible downstream.
          err_d = 1'b1;
          if (!mem_we_q) cpu_rd_d = '1;
          mem_req_d = 1'b0;
          state_d   = S_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        mem_req_d = 1'b0;
        state_d   = S_IDLE;
      end
    endcase
  end

  assign stall   = ~reset & ((state_q == S_WAIT) | ((state_q == S_IDLE) & cpu_req));
  assign cpu_rd  = cpu_rd_q;
  assign mem_adr = mem_adr_q;
  assign mem_wd  = mem_wd_q;
  assign mem_we  = mem_we_q;
  assign mem_req = mem_req_q;
  assign err     = err_q;

endmodule

// File: tb/tb_mem_wait_bridge.sv
// Directed bench for mem_wait_bridge: table of accesses with hand-computed results,
// plus hand sequences for reset behaviour, stray acks and reset in the middle of an access.
module tb_mem_wait_bridge;

  localparam int NOACK = 1000;

  logic       clk;
  logic       reset;
  logic [7:0] cpu_adr;
  logic [7:0] cpu_wd;
  logic       cpu_memread;
  logic       cpu_memwrite;
  logic [7:0] cpu_rd;
  logic       stall;
  logic [7:0] mem_adr;
  logic [7:0] mem_wd;
  logic       mem_we;
  logic       mem_req;
  logic       mem_ack;
  logic [7:0] mem_rd;
  logic       err;

  int checks = 0;
  int errors = 0;

  mem_wait_bridge #(.WIDTH(8), .AWIDTH(8), .TIMEOUT(15)) dut (
    .clk          (clk),
    .reset        (reset),
    .cpu_adr      (cpu_adr),
    .cpu_wd       (cpu_wd),
    .cpu_memread  (cpu_memread),
    .cpu_memwrite (cpu_memwrite),
    .cpu_rd       (cpu_rd),
    .stall        (stall),
    .mem_adr      (mem_adr),
    .mem_wd       (mem_wd),
    .mem_we       (mem_we),
    .mem_req      (mem_req),
    .mem_ack      (mem_ack),
    .mem_rd       (mem_rd),
    .err          (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] adr;
    logic [7:0] wd;
    logic       rd;
    logic       wr;
    int         waits;      // WAIT cycles before ack; NOACK never acks
    logic [7:0] data;
    logic       keep;       // keep request asserted through DONE (back-to-back)
    logic [7:0] exp_rd;
    logic       exp_we;
    logic       exp_err;
    int         exp_stall;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int  widx;
    int  scnt;
    bit  done;
    @(negedge clk);
    check("idle_req", mem_req, 0);
    cpu_adr      = v.adr;
    cpu_wd       = v.wd;
    cpu_memread  = v.rd;
    cpu_memwrite = v.wr;
    mem_ack      = 1'b0;
    #1;
    check("stall_accept", stall, 1);
    scnt = 1;
    widx = 0;
    done = 0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (stall) begin
        scnt++;
        check("wait_req", mem_req, 1);
        check("wait_adr", mem_adr, v.adr);
        check("wait_wd", mem_wd, v.wd);
        check("wait_we", mem_we, v.exp_we);
        cpu_adr = ~v.adr;
        cpu_wd  = ~v.wd;
        if (widx == v.waits) begin
          mem_ack = 1'b1;
          mem_rd  = v.data;
        end else begin
          mem_ack = 1'b0;
          mem_rd  = 8'h00;
        end
        widx++;
      end else begin
        done    = 1;
        mem_ack = 1'b0;
        check("done_req", mem_req, 0);
        check("done_cpu_rd", cpu_rd, v.exp_rd);
        check("done_err", err, v.exp_err);
        check("stall_cycles", scnt, v.exp_stall);
        if (v.keep) begin
          cpu_adr = v.adr;
          cpu_wd  = v.wd;
        end else begin
          cpu_memread  = 1'b0;
          cpu_memwrite = 1'b0;
        end
      end
    end
    if (!done) check("access_timeout", 1, 0);
  endtask

  initial begin
    //          adr    wd     rd    wr    waits  data   keep  exp_rd exp_we exp_err stall
    vecs[0]  = '{8'h04, 8'h00, 1'b1, 1'b0, 0,     8'hA5, 1'b0, 8'hA5, 1'b0,  1'b0,   2};
    vecs[1]  = '{8'h10, 8'h3C, 1'b0, 1'b1, 3,     8'h66, 1'b0, 8'hA5, 1'b1,  1'b0,   5};
    vecs[2]  = '{8'h20, 8'h5A, 1'b1, 1'b1, 1,     8'h77, 1'b0, 8'hA5, 1'b1,  1'b0,   3};
    vecs[3]  = '{8'h30, 8'h00, 1'b1, 1'b0, 2,     8'hC3, 1'b0, 8'hC3, 1'b0,  1'b0,   4};
    vecs[4]  = '{8'h00, 8'h00, 1'b1, 1'b0, 0,     8'h11, 1'b1, 8'h11, 1'b0,  1'b0,   2};
    vecs[5]  = '{8'h01, 8'h00, 1'b1, 1'b0, 0,     8'h22, 1'b1, 8'h22, 1'b0,  1'b0,   2};
    vecs[6]  = '{8'h02, 8'h00, 1'b1, 1'b0, 0,     8'h33, 1'b1, 8'h33, 1'b0,  1'b0,   2};
    vecs[7]  = '{8'h03, 8'h00, 1'b1, 1'b0, 0,     8'h44, 1'b0, 8'h44, 1'b0,  1'b0,   2};
    vecs[8]  = '{8'h40, 8'h00, 1'b1, 1'b0, NOACK, 8'h00, 1'b0, 8'hFF, 1'b0,  1'b1,   16};
    vecs[9]  = '{8'h41, 8'h00, 1'b1, 1'b0, 0,     8'h12, 1'b0, 8'h12, 1'b0,  1'b1,   2};
    vecs[10] = '{8'h50, 8'h99, 1'b0, 1'b1, 1,     8'hAB, 1'b0, 8'h12, 1'b1,  1'b1,   3};

    reset        = 1'b1;
    cpu_adr      = 8'h00;
    cpu_wd       = 8'h00;
    cpu_memread  = 1'b1;
    cpu_memwrite = 1'b0;
    mem_ack      = 1'b0;
    mem_rd       = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_stall", stall, 0);
    check("rst_req", mem_req, 0);
    check("rst_cpu_rd", cpu_rd, 0);
    check("rst_adr", mem_adr, 0);
    check("rst_wd", mem_wd, 0);
    check("rst_we", mem_we, 0);
    check("rst_err", err, 0);
    reset       = 1'b0;
    cpu_memread = 1'b0;

    for (int k = 0; k < 11; k++) run_vec(vecs[k]);

    // Stray acks while idle must not start or complete anything.
    @(negedge clk);
    mem_ack = 1'b1;
    mem_rd  = 8'hDD;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("stray_req", mem_req, 0);
      check("stray_stall", stall, 0);
      check("stray_cpu_rd", cpu_rd, 8'h12);
    end
    mem_ack = 1'b0;

    // Reset in the middle of a read, followed by a late ack.
    @(negedge clk);
    cpu_adr     = 8'h60;
    cpu_memread = 1'b1;
    @(negedge clk);
    check("mid_wait_req", mem_req, 1);
    reset = 1'b1;
    #1;
    check("mid_rst_stall_forced", stall, 0);
    @(negedge clk);
    check("mid_rst_req", mem_req, 0);
    check("mid_rst_stall", stall, 0);
    reset       = 1'b0;
    cpu_memread = 1'b0;
    mem_ack     = 1'b1;
    mem_rd      = 8'hEE;
    @(negedge clk);
    check("late_ack_cpu_rd", cpu_rd, 0);
    check("late_ack_req", mem_req, 0);
    check("late_ack_stall", stall, 0);
    check("late_ack_err", err, 0);
    mem_ack = 1'b0;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
